// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared fetch/decode pipeline types and constants
//
// Purpose: common definitions for the IF/ID fetch stage and its consumers.
//   fetch_state_e : RUN (normal fetch) / HOLD (decode stalled, skid occupied)
//   NOP_INSTR     : encoding loaded into IF/ID for invalid or killed slots
//   PC_INC_DEFAULT: default PC increment reported as pc_plus4
//   ifid_t        : IF/ID register bundle as seen by decode
package mips_pipe_pkg;

    localparam int              XLEN           = 32;
    localparam int unsigned     PC_INC_DEFAULT = 4;
    localparam logic [XLEN-1:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/if_id_skid_buffer.sv
// rtl/if_id_skid_buffer.sv - one-entry holding register for the fetch skid slot
//
// Purpose: captures one in-flight fetch response while decode is stalled.
// Ports:
//   clk     : system clock, rising edge
//   clear_i : empty the slot (dominates load_i)
//   load_i  : capture data_i/valid_i
//   data_i  : payload to hold
//   valid_i : payload valid flag
//   data_o  : held payload
//   valid_o : slot holds a valid entry
module if_id_skid_buffer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         valid_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [W-1:0] data_q;
    logic         valid_q;

    always_ff @(posedge clk) begin
        if (clear_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= valid_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - fetch stage from PC register to IF/ID pipeline register
//
// Purpose: pairs the synchronous IMEM response with the PC that requested it,
// loads IF/ID for decode, parks the in-flight word in a skid slot during a
// decode stall, kills wrong-path fetches on flush, and drives the PC enable.
// Optional macro IFID_PERF_CNT_EN adds stall/flush performance counters;
// without it both counter outputs are tied to 0.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   pc_i           : current PC, also this cycle's IMEM address
//   imem_rdata_i   : IMEM word for the address presented last cycle
//   stall_i        : decode stall request
//   flush_i        : taken branch/jump, PC loads its target this cycle
//   pc_enable_o    : PC register enable
//   instr_o        : IF/ID instruction
//   pc_plus4_o     : IF/ID PC + PC_INC
//   valid_o        : IF/ID entry valid
//   stall_cycles_o : cycles with an unflushed stall request
//   flush_count_o  : flushes that killed a valid entry
module if_id_fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter int          N      = XLEN,
    parameter int unsigned PC_INC = PC_INC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc_i,
    input  logic [N-1:0] imem_rdata_i,
    input  logic         stall_i,
    input  logic         flush_i,
    output logic         pc_enable_o,
    output logic [N-1:0] instr_o,
    output logic [N-1:0] pc_plus4_o,
    output logic         valid_o,
    output logic [31:0]  stall_cycles_o,
    output logic [31:0]  flush_count_o
);

    localparam logic [N-1:0] INC = N'(PC_INC);
    localparam logic [N-1:0] NOP = N'(NOP_INSTR);

    fetch_state_e state_q, state_d;
    logic [N-1:0] req_pc_q, req_pc_d;
    logic         req_valid_q, req_valid_d;
    logic [N-1:0] instr_q, instr_d;
    logic [N-1:0] pc_plus4_q, pc_plus4_d;
    logic         valid_q, valid_d;

    logic         skid_load;
    logic         skid_clear;
    logic [N-1:0] skid_instr;
    logic [N-1:0] skid_pc;
    logic         skid_valid;

    if_id_skid_buffer #(
        .W(2 * N)
    ) u_skid (
        .clk     (clk),
        .clear_i (skid_clear),
        .load_i  (skid_load),
        .data_i  ({imem_rdata_i, req_pc_q}),
        .valid_i (req_valid_q),
        .data_o  ({skid_instr, skid_pc}),
        .valid_o (skid_valid)
    );

    assign pc_enable_o = !reset && (flush_i || (!stall_i && state_q == RUN));

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        skid_load  = 1'b0;
        skid_clear = reset;
        req_pc_d   = pc_i;
        // The release cycle keeps the PC frozen, so the held PC is read a
        // second time; the earlier of the two identical responses is marked
        // invalid, giving one bubble instead of a duplicated instruction.
        req_valid_d = !flush_i && !reset && !(state_q == HOLD && !stall_i);

        if (flush_i) begin
            instr_d    = NOP;
            valid_d    = 1'b0;
            state_d    = RUN;
            skid_clear = 1'b1;
        end else if (state_q == RUN) begin
            if (stall_i) begin
                skid_load = 1'b1;
                state_d   = HOLD;
            end else begin
                instr_d    = req_valid_q ? imem_rdata_i : NOP;
                pc_plus4_d = req_pc_q + INC;
                valid_d    = req_valid_q;
            end
        end else if (!stall_i) begin
            instr_d    = skid_valid ? skid_instr : NOP;
            pc_plus4_d = skid_pc + INC;
            valid_d    = skid_valid;
            skid_clear = 1'b1;
            state_d    = RUN;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
        if (reset) begin
            state_q     <= RUN;
            req_valid_q <= 1'b0;
            instr_q     <= NOP;
            pc_plus4_q  <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            instr_q     <= instr_d;
            pc_plus4_q  <= pc_plus4_d;
            valid_q     <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_i && !flush_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_i && (valid_q || skid_valid)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;
`else
    assign stall_cycles_o = 32'd0;
    assign flush_count_o  = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb/tb_if_id_fetch_stage.sv - self-checking bench for if_id_fetch_stage
module tb_if_id_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] target;
    logic [31:0] pc_q = 32'd0;
    logic [31:0] imem_rdata = 32'd0;
    logic        pc_enable;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    // Architectural instruction stream still owed to decode, oldest first.
    ent_t exp_q[$];
    bit          mon_en     = 1'b0;
    bit          prev_reset = 1'b1;
    bit          prev_hold  = 1'b0;
    bit          new_occ    = 1'b1;
    bit          last_valid = 1'b0;
    logic [31:0] last_instr = 32'd0;
    logic [31:0] last_pc4   = 32'd0;

    always #5 clk = ~clk;

    if_id_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .pc_i           (pc_q),
        .imem_rdata_i   (imem_rdata),
        .stall_i        (stall),
        .flush_i        (flush),
        .pc_enable_o    (pc_enable),
        .instr_o        (instr),
        .pc_plus4_o     (pc_plus4),
        .valid_o        (valid),
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h2008_0005;
        if (a == 32'd4) return 32'h2009_0003;
        return {8'h8C, a[23:0]};
    endfunction

    // PC register and synchronous-read instruction memory.
    always @(posedge clk) begin
        if (reset) pc_q <= 32'd0;
        else if (pc_enable) pc_q <= flush ? target : pc_q + 32'd4;
        imem_rdata <= imem_word(pc_q);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Stream model: each PC value the PC register takes is one instruction;
    // a flush kills everything not yet delivered, reset kills everything;
    // IF/ID must freeze on any cycle after an unflushed stall.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   exp_en;
            ent_t e;
            exp_en = !reset && (flush || (!stall && !prev_hold));
            chk("pc_enable", 32'(pc_enable), 32'(exp_en));
            if (prev_reset) begin
                chk("reset_valid", 32'(valid), 32'd0);
                chk("reset_instr", instr, 32'd0);
                chk("reset_pc4", pc_plus4, 32'd0);
                last_valid = 1'b0;
                last_instr = 32'd0;
            end else if (prev_hold) begin
                chk("frozen_valid", 32'(valid), 32'(last_valid));
                chk("frozen_instr", instr, last_instr);
                if (last_valid) chk("frozen_pc4", pc_plus4, last_pc4);
            end else if (valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream_extra: got valid instr %h expected no entry at %0t", instr, $time);
                    last_valid = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_instr", instr, e.instr);
                    chk("stream_pc4", pc_plus4, e.pc4);
                    last_valid = 1'b1;
                    last_instr = e.instr;
                    last_pc4   = e.pc4;
                end
            end else begin
                chk("nop_on_invalid", instr, 32'd0);
                last_valid = 1'b0;
                last_instr = 32'd0;
            end
`ifndef IFID_PERF_CNT_EN
            chk("stall_cnt_tied", stall_cycles, 32'd0);
            chk("flush_cnt_tied", flush_count, 32'd0);
`endif
            if (reset) begin
                exp_q.delete();
                new_occ = 1'b1;
            end else begin
                if (new_occ) exp_q.push_back('{imem_word(pc_q), pc_q + 32'd4});
                if (flush) exp_q.delete();
                new_occ = exp_en;
            end
            prev_hold  = stall && !flush && !reset;
            prev_reset = reset;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        stall  = 1'b0;
        flush  = 1'b0;
        target = 32'd0;
        repeat (3) step();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc4", pc_plus4, 32'd0);
        chk("rst_pc_en", 32'(pc_enable), 32'd0);
        chk("rst_stall_cnt", stall_cycles, 32'd0);
        chk("rst_flush_cnt", flush_count, 32'd0);
        mon_en = 1'b1;
        reset  = 1'b0;

        // First valid word two cycles after reset release.
        step(); chk("c1_valid", 32'(valid), 32'd0);
        step(); chk("c2_instr", instr, 32'h2008_0005); chk("c2_pc4", pc_plus4, 32'd4);
                chk("c2_valid", 32'(valid), 32'd1);
        step(); chk("c3_instr", instr, 32'h2009_0003); chk("c3_pc4", pc_plus4, 32'd8);
        step(); step(); chk("pre_stall_pc4", pc_plus4, 32'h10);

        // Three stall cycles while the word for 0x10 is arriving.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; chk("stall_pc_en", 32'(pc_enable), 32'd0);
            step(); chk("stall_frozen", instr, imem_word(32'hC));
        end
        stall = 1'b0;
        #1; chk("release_pc_en", 32'(pc_enable), 32'd0);
        step(); chk("rel_instr", instr, imem_word(32'h10)); chk("rel_pc4", pc_plus4, 32'h14);
        #1; chk("post_rel_pc_en", 32'(pc_enable), 32'd1);
        step(); chk("bubble_valid", 32'(valid), 32'd0);
        step(); chk("after_instr", instr, imem_word(32'h14)); chk("after_pc4", pc_plus4, 32'h18);

        // Flush at PC 0x20 to target 0x40.
        step(); chk("flush_at_pc", pc_q, 32'h20);
        flush = 1'b1; target = 32'h40;
        #1; chk("flush_pc_en", 32'(pc_enable), 32'd1);
        step(); chk("flush_valid", 32'(valid), 32'd0); chk("flush_instr", instr, 32'd0);
        flush = 1'b0;
        step(); chk("wrongpath_valid", 32'(valid), 32'd0);
        step(); chk("tgt_instr", instr, imem_word(32'h40)); chk("tgt_pc4", pc_plus4, 32'h44);

        // Flush together with stall while in HOLD.
        stall = 1'b1;
        step(); step();
        flush = 1'b1; target = 32'h80;
        #1; chk("fs_pc_en", 32'(pc_enable), 32'd1);
        step(); chk("fs_valid", 32'(valid), 32'd0);
        flush = 1'b0; stall = 1'b0;
        #1; chk("fs_run_pc_en", 32'(pc_enable), 32'd1);
        step(); chk("fs_wrong_valid", 32'(valid), 32'd0);
        step(); chk("fs_tgt_instr", instr, imem_word(32'h80));

        // Reset asserted while in HOLD.
        stall = 1'b1;
        step(); step();
        reset = 1'b1;
        #1; chk("rh_pc_en", 32'(pc_enable), 32'd0);
        step(); chk("rh_valid", 32'(valid), 32'd0); chk("rh_instr", instr, 32'd0);
                chk("rh_pc4", pc_plus4, 32'd0); chk("rh_stall_cnt", stall_cycles, 32'd0);
        reset = 1'b0; stall = 1'b0;
        #1; chk("rh_run_pc_en", 32'(pc_enable), 32'd1);

        // Five stall cycles and two flushes of valid entries.
        repeat (4) step();
        stall = 1'b1;
        repeat (5) step();
        stall = 1'b0;
        repeat (4) step();
        chk("perf_pre_flush1_valid", 32'(valid), 32'd1);
        flush = 1'b1; target = 32'h100;
        step(); flush = 1'b0;
        step(); step();
        chk("perf_pre_flush2_valid", 32'(valid), 32'd1);
        flush = 1'b1; target = 32'h200;
        step(); flush = 1'b0;
        step();
`ifdef IFID_PERF_CNT_EN
        chk("perf_stall_cnt", stall_cycles, 32'd5);
        chk("perf_flush_cnt", flush_count, 32'd2);
`else
        chk("perf_stall_off", stall_cycles, 32'd0);
        chk("perf_flush_off", flush_count, 32'd0);
`endif

        // PC+4 wraps modulo 2^32.
        flush = 1'b1; target = 32'hFFFF_FFF8;
        step(); flush = 1'b0;
        step(); step();
        chk("wrap_f8_instr", instr, imem_word(32'hFFFF_FFF8)); chk("wrap_f8_pc4", pc_plus4, 32'hFFFF_FFFC);
        step(); chk("wrap_pc4", pc_plus4, 32'd0); chk("wrap_valid", 32'(valid), 32'd1);
        step(); chk("wrap_zero_instr", instr, 32'h2008_0005); chk("wrap_zero_pc4", pc_plus4, 32'd4);

        // Free run: only the arriving word and the current PC may be owed.
        repeat (4) step();
        chk("inflight_depth", 32'(exp_q.size()), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
